// File: rtl/batch_scheduler_pq_pkg.sv
// batch_scheduler_pq_pkg: FSM encoding, default table geometry and clog2 helper
package batch_scheduler_pq_pkg;
  typedef enum logic [2:0] {PQ_IDLE, PQ_COLLECT, PQ_SELECT, PQ_ISSUE, PQ_DONE} pq_state_t;
  localparam int PQ_REQ_DEPTH  = 32;
  localparam int PQ_SRR_DEPTH  = 16;
  localparam int PQ_SBR_DEPTH  = 8;
  localparam int PQ_HIT_TAG_W  = 16;
  localparam int PQ_MISS_TAG_W = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/batch_scheduler_pq_if.sv
// batch_scheduler_pq_if: batch request stream, issue stream and status bundle
interface batch_scheduler_pq_if
  import batch_scheduler_pq_pkg::*;
#(
  parameter int REQ_DEPTH  = PQ_REQ_DEPTH,
  parameter int SBR_DEPTH  = PQ_SBR_DEPTH,
  parameter int HIT_TAG_W  = PQ_HIT_TAG_W,
  parameter int MISS_TAG_W = PQ_MISS_TAG_W
);
  localparam int RID_W = clog2(REQ_DEPTH);
  localparam int SBR_W = clog2(SBR_DEPTH);
  logic                  start, crit_mode;
  logic                  in_valid, in_ready, in_last;
  logic [HIT_TAG_W-1:0]  in_hit_tag;
  logic [MISS_TAG_W-1:0] in_miss_tag;
  logic                  out_valid, out_ready, out_last;
  logic [RID_W-1:0]      out_req_id;
  logic [SBR_W-1:0]      out_sbr, critical_sbr;
  logic                  busy, done, forced_close;
  modport master (
    output start, crit_mode, in_valid, in_hit_tag, in_miss_tag, in_last, out_ready,
    input  in_ready, out_valid, out_req_id, out_sbr, out_last, busy, done, forced_close, critical_sbr
  );
  modport slave (
    input  start, crit_mode, in_valid, in_hit_tag, in_miss_tag, in_last, out_ready,
    output in_ready, out_valid, out_req_id, out_sbr, out_last, busy, done, forced_close, critical_sbr
  );
endinterface

// File: rtl/batch_scheduler_pq_cam.sv
// sched_tag_cam: single-cycle tag lookup over valid entries, lowest matching index wins
module sched_tag_cam
  import batch_scheduler_pq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = 16,
  localparam int IW   = clog2(DEPTH)
)(
  input  logic [DEPTH-1:0]            i_valid,
  input  logic [DEPTH-1:0][TAG_W-1:0] i_tags,
  input  logic [TAG_W-1:0]            i_tag,
  output logic                        o_hit,
  output logic [IW-1:0]               o_idx
);
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (i_valid[i] && i_tags[i] == i_tag) begin
        o_hit = 1'b1;
        o_idx = IW'(i);
      end
  end
endmodule

// File: rtl/batch_scheduler_pq.sv
// batch_scheduler_pq: groups a batch into row (SRR) and bank (SBR) chains, then issues
// request IDs bank by bank, critical-path-first or in allocation order
module batch_scheduler_pq
  import batch_scheduler_pq_pkg::*;
#(
  parameter int REQ_DEPTH  = PQ_REQ_DEPTH,
  parameter int SRR_DEPTH  = PQ_SRR_DEPTH,
  parameter int SBR_DEPTH  = PQ_SBR_DEPTH,
  parameter int HIT_TAG_W  = PQ_HIT_TAG_W,
  parameter int MISS_TAG_W = PQ_MISS_TAG_W
)(
  input logic clk,
  input logic rst_n,
  batch_scheduler_pq_if.slave bus
);
  localparam int RID_W = clog2(REQ_DEPTH);
  localparam int SRR_W = clog2(SRR_DEPTH);
  localparam int SBR_W = clog2(SBR_DEPTH);
  localparam logic [RID_W:0] REQ_LIM = (RID_W+1)'(REQ_DEPTH);
  localparam logic [SRR_W:0] SRR_LIM = (SRR_W+1)'(SRR_DEPTH);
  localparam logic [SBR_W:0] SBR_LIM = (SBR_W+1)'(SBR_DEPTH);
  localparam logic [RID_W:0] REQ_TOP = (RID_W+1)'(REQ_DEPTH-1);
  localparam logic [SRR_W:0] SRR_TOP = (SRR_W+1)'(SRR_DEPTH-1);
  localparam logic [SBR_W:0] SBR_TOP = (SBR_W+1)'(SBR_DEPTH-1);
  pq_state_t r_state, w_next;
  logic [RID_W:0] r_req_cnt, r_issued_cnt;
  logic [SRR_W:0] r_srr_cnt;
  logic [SBR_W:0] r_sbr_cnt;
  logic r_crit, r_forced, r_first, r_found;
  logic [SBR_W-1:0] r_critical, r_cur_sbr, r_scan, r_best;
  logic [SRR_W-1:0] r_cur_srr;
  logic [RID_W-1:0] r_cur_req;
  logic [REQ_DEPTH-1:0][RID_W-1:0] r_req_next;
  logic [SRR_DEPTH-1:0] r_srr_valid;
  logic [SRR_DEPTH-1:0][HIT_TAG_W-1:0] r_srr_tag;
  logic [SRR_DEPTH-1:0][RID_W-1:0] r_srr_head, r_srr_tail;
  logic [SRR_DEPTH-1:0][SRR_W-1:0] r_srr_next;
  logic [SRR_DEPTH-1:0][SBR_W-1:0] r_srr_sbr;
  logic [SBR_DEPTH-1:0] r_sbr_valid, r_sbr_issued;
  logic [SBR_DEPTH-1:0][MISS_TAG_W-1:0] r_sbr_tag;
  logic [SBR_DEPTH-1:0][SRR_W-1:0] r_sbr_head, r_sbr_tail;
  logic [SBR_DEPTH-1:0][RID_W:0] r_sbr_total;
  logic w_rdy, w_acc, w_srr_hit, w_sbr_hit, w_full, w_take, w_sel_done, w_fire, w_srr_end, w_sbr_end, w_more;
  logic [SRR_W-1:0] w_srr_idx, w_new_srr;
  logic [SBR_W-1:0] w_sbr_idx, w_new_sbr, w_sel, w_low;
  logic [RID_W-1:0] w_id;
  logic [SBR_DEPTH-1:0] w_pend;
  sched_tag_cam #(.DEPTH(SRR_DEPTH), .TAG_W(HIT_TAG_W)) u_srr_cam (
    .i_valid(r_srr_valid), .i_tags(r_srr_tag), .i_tag(bus.in_hit_tag), .o_hit(w_srr_hit), .o_idx(w_srr_idx)
  );
  sched_tag_cam #(.DEPTH(SBR_DEPTH), .TAG_W(MISS_TAG_W)) u_sbr_cam (
    .i_valid(r_sbr_valid), .i_tags(r_sbr_tag), .i_tag(bus.in_miss_tag), .o_hit(w_sbr_hit), .o_idx(w_sbr_idx)
  );
  assign w_id      = r_req_cnt[RID_W-1:0];
  assign w_new_srr = r_srr_cnt[SRR_W-1:0];
  assign w_new_sbr = r_sbr_cnt[SBR_W-1:0];
  assign w_rdy     = r_state == PQ_COLLECT && r_req_cnt < REQ_LIM && r_srr_cnt < SRR_LIM && r_sbr_cnt < SBR_LIM;
  assign w_acc     = w_rdy && bus.in_valid;
  // close early when this accept fills whichever table it allocates into
  assign w_full    = r_req_cnt == REQ_TOP || (!w_srr_hit && (r_srr_cnt == SRR_TOP || (!w_sbr_hit && r_sbr_cnt == SBR_TOP)));
  assign w_pend    = r_sbr_valid & ~r_sbr_issued;
  assign w_take    = w_pend[r_scan] && (!r_found || r_sbr_total[r_scan] > r_sbr_total[r_best]);
  assign w_sel     = r_crit ? (w_take ? r_scan : r_best) : w_low;
  assign w_sel_done = !r_crit || {1'b0, r_scan} == r_sbr_cnt - (SBR_W+1)'(1);
  assign w_fire    = r_state == PQ_ISSUE && bus.out_ready;
  assign w_srr_end = r_cur_req == r_srr_tail[r_cur_srr];
  assign w_sbr_end = r_cur_srr == r_sbr_tail[r_cur_sbr];
  assign w_more    = |(w_pend & ~(SBR_DEPTH'(1) << r_cur_sbr));
  always_comb begin
    w_low = '0;
    for (int i = SBR_DEPTH-1; i >= 0; i--)
      if (w_pend[i]) w_low = SBR_W'(i);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      PQ_IDLE:    if (bus.start) w_next = PQ_COLLECT;
      PQ_COLLECT: if (w_acc && (bus.in_last || w_full)) w_next = PQ_SELECT;
      PQ_SELECT:  if (w_sel_done) w_next = PQ_ISSUE;
      PQ_ISSUE:   if (w_fire && w_srr_end && w_sbr_end) w_next = w_more ? PQ_SELECT : PQ_DONE;
      default:    w_next = PQ_IDLE;
    endcase
    bus.in_ready  = w_rdy;
    bus.out_valid = r_state == PQ_ISSUE;
    bus.out_last  = r_state == PQ_ISSUE && r_issued_cnt == r_req_cnt - (RID_W+1)'(1);
    bus.busy      = r_state != PQ_IDLE;
    bus.done      = r_state == PQ_DONE;
  end
  assign bus.out_req_id   = r_cur_req;
  assign bus.out_sbr      = r_cur_sbr;
  assign bus.forced_close = r_forced;
  assign bus.critical_sbr = r_critical;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= PQ_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_req_cnt, r_issued_cnt, r_srr_cnt, r_sbr_cnt} <= '0;
      {r_crit, r_forced, r_first, r_found} <= '0;
      {r_critical, r_cur_sbr, r_scan, r_best, r_cur_srr, r_cur_req} <= '0;
      {r_srr_valid, r_sbr_valid, r_sbr_issued} <= '0;
      r_req_next <= '0;
      {r_srr_tag, r_srr_head, r_srr_tail, r_srr_next, r_srr_sbr} <= '0;
      {r_sbr_tag, r_sbr_head, r_sbr_tail, r_sbr_total} <= '0;
    end else begin
      if (r_state == PQ_IDLE && bus.start) begin
        {r_req_cnt, r_issued_cnt, r_srr_cnt, r_sbr_cnt} <= '0;
        {r_srr_valid, r_sbr_valid, r_sbr_issued} <= '0;
        r_crit     <= bus.crit_mode;
        r_forced   <= 1'b0;
        r_first    <= 1'b1;
        r_critical <= '0;
      end
      if (w_acc) begin
        r_req_cnt <= r_req_cnt + (RID_W+1)'(1);
        r_forced  <= r_forced | w_full;
        if (w_srr_hit) begin
          r_req_next[r_srr_tail[w_srr_idx]] <= w_id;
          r_srr_tail[w_srr_idx] <= w_id;
          r_sbr_total[r_srr_sbr[w_srr_idx]] <= r_sbr_total[r_srr_sbr[w_srr_idx]] + (RID_W+1)'(1);
        end else begin
          r_srr_cnt <= r_srr_cnt + (SRR_W+1)'(1);
          r_srr_valid[w_new_srr] <= 1'b1;
          r_srr_tag[w_new_srr]   <= bus.in_hit_tag;
          r_srr_head[w_new_srr]  <= w_id;
          r_srr_tail[w_new_srr]  <= w_id;
          if (w_sbr_hit) begin
            r_srr_next[r_sbr_tail[w_sbr_idx]] <= w_new_srr;
            r_sbr_tail[w_sbr_idx]  <= w_new_srr;
            r_srr_sbr[w_new_srr]   <= w_sbr_idx;
            r_sbr_total[w_sbr_idx] <= r_sbr_total[w_sbr_idx] + (RID_W+1)'(1);
          end else begin
            r_sbr_cnt <= r_sbr_cnt + (SBR_W+1)'(1);
            r_sbr_valid[w_new_sbr] <= 1'b1;
            r_sbr_tag[w_new_sbr]   <= bus.in_miss_tag;
            r_sbr_head[w_new_sbr]  <= w_new_srr;
            r_sbr_tail[w_new_sbr]  <= w_new_srr;
            r_sbr_total[w_new_sbr] <= (RID_W+1)'(1);
            r_srr_sbr[w_new_srr]   <= w_new_sbr;
          end
        end
      end
      if (r_state == PQ_SELECT) begin
        r_scan <= r_scan + SBR_W'(1);
        if (w_take) begin
          r_best  <= r_scan;
          r_found <= 1'b1;
        end
        if (w_sel_done) begin
          r_cur_sbr <= w_sel;
          r_cur_srr <= r_sbr_head[w_sel];
          r_cur_req <= r_srr_head[r_sbr_head[w_sel]];
          if (r_crit && r_first) begin
            r_critical <= w_sel;
            r_first    <= 1'b0;
          end
        end
      end else begin
        r_scan  <= '0;
        r_found <= 1'b0;
      end
      // walk requests within the row, then hop to the next row of the same bank
      if (w_fire) begin
        r_issued_cnt <= r_issued_cnt + (RID_W+1)'(1);
        if (!w_srr_end) r_cur_req <= r_req_next[r_cur_req];
        else if (!w_sbr_end) begin
          r_cur_srr <= r_srr_next[r_cur_srr];
          r_cur_req <= r_srr_head[r_srr_next[r_cur_srr]];
        end else r_sbr_issued[r_cur_sbr] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_batch_scheduler_pq.sv
// tb_batch_scheduler_pq: directed batches against a queue of expected issue beats
module tb_batch_scheduler_pq;
  typedef struct packed { logic [4:0] id; logic [2:0] sbr; logic last; } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bp = 1'b0;
  logic rdy = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;
  int bp_cnt = 0;
  exp_t exp_q[$];
  batch_scheduler_pq_if bus ();
  batch_scheduler_pq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  task automatic push(input int id, input int sbr, input logic last);
    exp_q.push_back('{5'(id), 3'(sbr), last});
  endtask
  initial forever begin
    @(negedge clk);
    if (bus.done === 1'b1) n_done++;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected issue: got id %0d, expected none", bus.out_req_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_req_id", bus.out_req_id, e.id);
        chk("out_sbr", bus.out_sbr, e.sbr);
        chk("out_last", bus.out_last, e.last);
      end
    end
  end
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = bp ? (bp_cnt % 4 == 0 || bp_cnt % 4 == 3) : rdy;
      bp_cnt = bp ? bp_cnt + 1 : 0;
    end
  end
  task automatic open(input logic crit);
    bus.start = 1'b1;
    bus.crit_mode = crit;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.crit_mode = 1'b0;
  endtask
  task automatic send(input int h, input int m, input logic l, input logic exp_ok = 1'b1);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_hit_tag = 16'(h);
    bus.in_miss_tag = 8'(m);
    bus.in_last = l;
    for (int k = 0; k < (exp_ok ? 20 : 3) && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    chk("accept", ok, exp_ok);
  endtask
  task automatic wait_done(input int forced, input int crit_sbr);
    int d0;
    d0 = n_done;
    for (int k = 0; k < 400 && n_done == d0; k++) @(posedge clk);
    chk("done pulse", n_done - d0, 1);
    @(posedge clk); #1;
    chk("drained", exp_q.size(), 0);
    chk("busy", bus.busy, 0);
    chk("done width", bus.done, 0);
    chk("forced_close", bus.forced_close, forced);
    chk("critical_sbr", bus.critical_sbr, crit_sbr);
  endtask
  initial begin
    int d0;
    bus.start = 1'b0;
    bus.crit_mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_hit_tag = '0;
    bus.in_miss_tag = '0;
    bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset in_ready", bus.in_ready, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset forced_close", bus.forced_close, 0);
    chk("reset critical_sbr", bus.critical_sbr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(0, 0, 0); push(2, 0, 0); push(3, 0, 0); push(1, 1, 1);
    open(1'b0);
    send('hA, 0, 0); send('hB, 1, 0); send('hA, 0, 0); send('hC, 0, 1);
    wait_done(0, 0);
    push(0, 0, 0); push(2, 0, 0); push(3, 0, 0); push(1, 1, 1);
    open(1'b1);
    send('hA, 0, 0); send('hB, 1, 0); send('hA, 0, 0); send('hC, 0, 1);
    wait_done(0, 0);
    push(1, 1, 0); push(2, 1, 0); push(3, 1, 0); push(0, 0, 1);
    open(1'b1);
    send('hB, 0, 0); send('hA, 1, 0); send('hA, 1, 0); send('hC, 1, 1);
    wait_done(0, 1);
    push(0, 0, 0); push(1, 1, 1);
    open(1'b1);
    send('hA, 0, 0); send('hB, 1, 1);
    wait_done(0, 0);
    for (int i = 0; i < 8; i++) push(i, i, i == 7);
    open(1'b0);
    for (int i = 0; i < 8; i++) send('h100 + i, i, 0);
    send('h108, 8, 1, 1'b0);
    wait_done(1, 0);
    bp = 1'b1;
    push(0, 0, 0); push(2, 0, 0); push(5, 0, 0); push(4, 0, 0); push(1, 1, 0); push(3, 1, 1);
    open(1'b0);
    send('hA, 0, 0); send('hB, 1, 0); send('hA, 2, 0); send('hC, 1, 0); send('hD, 0, 0); send('hA, 1, 1);
    wait_done(0, 0);
    bp = 1'b0;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    open(1'b1);
    send('h1, 0, 0); send('h2, 1, 1);
    for (int k = 0; k < 50 && bus.out_valid !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    chk("reach issue", bus.out_valid, 1);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", bus.out_valid, 0);
    chk("midreset busy", bus.busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no done after reset", n_done - d0, 0);
    push(0, 0, 1);
    open(1'b0);
    send('h55, 5, 1);
    wait_done(0, 0);
    for (int i = 0; i < 32; i++) push(i, 0, i == 31);
    open(1'b0);
    for (int i = 0; i < 32; i++) send('h777, 3, 0);
    wait_done(1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
